// File: rtl/product_accumulator_pkg.sv
// Shared types and widths for the product accumulator and its 2x2 multiplier.
package product_accumulator_pkg;
  localparam int OP_W   = 2;
  localparam int PROD_W = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;
endpackage

// File: rtl/mult_2x2.sv
// Combinational 2x2 unsigned multiplier built from partial-product ANDs and two half adders.
module mult_2x2
  import product_accumulator_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);
  logic a0b0, a0b1, a1b0, a1b1, c1;

  assign a0b0 = a[0] & b[0];
  assign a0b1 = a[0] & b[1];
  assign a1b0 = a[1] & b[0];
  assign a1b1 = a[1] & b[1];

  // First half adder folds the two middle partial products; second adds its carry to a1b1.
  assign c1   = a0b1 & a1b0;
  assign p[0] = a0b0;
  assign p[1] = a0b1 ^ a1b0;
  assign p[2] = a1b1 ^ c1;
  assign p[3] = a1b1 & c1;
endmodule

// File: rtl/product_accumulator.sv
// Sums LEN products of 2-bit operand pairs; result valid the cycle after the LENth accept.
// in_ready drops while a result is held; the held result waits on out_ready indefinitely.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = 8,
  parameter int LEN   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W-1:0]            a,
  input  logic [OP_W-1:0]            b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           acc,
  output logic [$clog2(LEN+1)-1:0]   count,
  output logic                       overflow
);
  localparam int CNT_W = $clog2(LEN + 1);

  state_t            state;
  logic [PROD_W-1:0] prod;
  logic [ACC_W:0]    sum;
  logic              accept;

  mult_2x2 u_mult (
    .a (a),
    .b (b),
    .p (prod)
  );

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;

  // One extra bit on the adder exposes the wrap for the sticky overflow flag.
  assign sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state    <= ACCUM;
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc   <= sum[ACC_W-1:0];
            count <= count + CNT_W'(1);
            if (sum[ACC_W]) overflow <= 1'b1;
            if (count == CNT_W'(LEN - 1)) state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state    <= ACCUM;
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three parameterisations share stimulus; results go through per-instance scoreboards.
module tb_product_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic out_ready = 1'b0;
  logic [1:0] a = '0;
  logic [1:0] b = '0;
  logic iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0;

  logic       ir0, ov0, of0;
  logic [7:0] acc0;
  logic [2:0] cnt0;
  logic       ir1, ov1, of1;
  logic [7:0] acc1;
  logic [0:0] cnt1;
  logic       ir2, ov2, of2;
  logic [3:0] acc2;
  logic [1:0] cnt2;

  int total = 0;
  int bad = 0;
  int q0[$];
  int q1[$];
  int q2[$];

  always #5 clk = ~clk;

  product_accumulator u0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b),
    .out_valid(ov0), .out_ready(out_ready), .acc(acc0), .count(cnt0), .overflow(of0)
  );

  product_accumulator #(.ACC_W(8), .LEN(1)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
    .out_valid(ov1), .out_ready(out_ready), .acc(acc1), .count(cnt1), .overflow(of1)
  );

  product_accumulator #(.ACC_W(4), .LEN(2)) u2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(iv2), .in_ready(ir2), .a(a), .b(b),
    .out_valid(ov2), .out_ready(out_ready), .acc(acc2), .count(cnt2), .overflow(of2)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Result transfers happen on the next rising edge; scoreboard entries are {overflow, acc}.
  always @(negedge clk) begin
    if (!rst && ov0 && out_ready) begin
      if (q0.size() == 0) check("u0_unexpected", 1, 0);
      else check("u0_result", int'({of0, 8'b0}) | int'(acc0), q0.pop_front());
    end
    if (!rst && ov1 && out_ready) begin
      if (q1.size() == 0) check("u1_unexpected", 1, 0);
      else check("u1_result", int'({of1, 8'b0}) | int'(acc1), q1.pop_front());
    end
    if (!rst && ov2 && out_ready) begin
      if (q2.size() == 0) check("u2_unexpected", 1, 0);
      else check("u2_result", int'({of2, 8'b0}) | int'(acc2), q2.pop_front());
    end
  end

  initial begin
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", int'(ir0), 1);
    check("rst_out_valid", int'(ov0), 0);
    check("rst_acc", int'(acc0), 0);
    check("rst_count", int'(cnt0), 0);
    check("rst_overflow", int'(of0), 0);

    // Four back-to-back (3,3) accepts.
    q0.push_back(36);
    for (int i = 0; i < 4; i++) begin
      iv0 = 1'b1; a = 2'd3; b = 2'd3;
      step();
      check("mac_acc", int'(acc0), 9 * (i + 1));
      check("mac_count", int'(cnt0), i + 1);
    end
    check("hold_out_valid", int'(ov0), 1);
    check("hold_in_ready", int'(ir0), 0);
    check("hold_overflow", int'(of0), 0);

    // Backpressure: in_valid stays high with (1,1) while out_ready is low.
    a = 2'd1; b = 2'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_out_valid", int'(ov0), 1);
      check("bp_acc", int'(acc0), 36);
      check("bp_count", int'(cnt0), 4);
      check("bp_in_ready", int'(ir0), 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("xfer_out_valid", int'(ov0), 0);
    check("xfer_acc", int'(acc0), 0);
    check("xfer_in_ready", int'(ir0), 1);
    step();
    check("b2b_acc", int'(acc0), 1);
    check("b2b_count", int'(cnt0), 1);

    // Plain clear, then clear colliding with an offered pair.
    iv0 = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_idle_acc", int'(acc0), 0);
    iv0 = 1'b1; a = 2'd2; b = 2'd1;
    step();
    check("clr_pre_acc1", int'(acc0), 2);
    step();
    check("clr_pre_acc2", int'(acc0), 4);
    clear = 1'b1; a = 2'd3; b = 2'd3;
    step();
    clear = 1'b0; iv0 = 1'b0;
    check("clr_acc", int'(acc0), 0);
    check("clr_count", int'(cnt0), 0);
    check("clr_in_ready", int'(ir0), 1);
    step();
    check("clr_pair_dropped", int'(acc0), 0);

    // Reset while a result is held: the result is lost.
    iv0 = 1'b1; a = 2'd3; b = 2'd3;
    for (int i = 0; i < 4; i++) step();
    iv0 = 1'b0;
    check("rsthold_acc", int'(acc0), 36);
    check("rsthold_out_valid", int'(ov0), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rsthold_ov_after", int'(ov0), 0);
    check("rsthold_acc_after", int'(acc0), 0);
    check("rsthold_cnt_after", int'(cnt0), 0);
    check("rsthold_ir_after", int'(ir0), 1);

    // LEN=1: every product in turn.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        a = 2'(i); b = 2'(j); iv1 = 1'b1;
        q1.push_back(i * j);
        step();
        check("len1_acc", int'(acc1), i * j);
        check("len1_out_valid", int'(ov1), 1);
        iv1 = 1'b0;
        step();
        check("len1_drained", int'(ov1), 0);
      end
    end
    out_ready = 1'b0;

    // ACC_W=4, LEN=2: 9+9 wraps to 2 with overflow.
    iv2 = 1'b1; a = 2'd3; b = 2'd3;
    q2.push_back(256 + 2);
    step();
    check("ovf_acc1", int'(acc2), 9);
    check("ovf_flag1", int'(of2), 0);
    step();
    iv2 = 1'b0;
    check("ovf_acc2", int'(acc2), 2);
    check("ovf_flag2", int'(of2), 1);
    check("ovf_out_valid", int'(ov2), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("ovf_acc_after", int'(acc2), 0);
    check("ovf_flag_after", int'(of2), 0);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
